div_unit: RTL and testbench

- Iterative multi-cycle divider for the RV32M divide group: DIV, DIVU, REM, REMU.
- Complements the single-cycle combinational integer ALU. It takes the same operand pair and returns one result word after a start/valid handshake.
- Sits in the execute stage beside the ALU. Control logic stalls the pipeline while busy is high.

---
 rtl/div_if.sv | 25 ++
 rtl/div_unit.sv | 149 ++++++++++++++
 tb/tb_div_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Handshake bundle for the iterative divider. The execute-stage control
// drives the request side (master); div_unit consumes it (slave).
interface div_if #(
  parameter int XLEN     = 32,
  parameter int OP_WIDTH = 2
);
  logic                start;
  logic [OP_WIDTH-1:0] div_op;
  logic [XLEN-1:0]     div_src1;
  logic [XLEN-1:0]     div_src2;
  logic                kill;
  logic                busy;
  logic                res_valid;
  logic [XLEN-1:0]     div_res;

  modport master (
    output start, div_op, div_src1, div_src2, kill,
    input  busy, res_valid, div_res
  );

  modport slave (
    input  start, div_op, div_src1, div_src2, kill,
    output busy, res_valid, div_res
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle, MSB first; divide-by-zero and signed overflow
// are resolved at acceptance and skip the iteration.
// Optional macro DIV_EARLY_OUT_EN: when |src1| < |src2| (divisor nonzero)
// the result is produced at acceptance instead of after XLEN iterations.
module div_unit #(
  parameter int XLEN     = 32,
  parameter int OP_WIDTH = 2
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic              sel_rem_q, sel_rem_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              is_signed;
  logic [XLEN-1:0]   mag1, mag2;
  logic [XLEN+1:0]   rem_sh;
  logic [XLEN+1:0]   diff;
  logic              ge;
  logic [XLEN:0]     rem_nx;
  logic [XLEN-1:0]   quo_nx;

  // Two's-complement negate when requested; used for magnitudes and sign fix-up.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Operand magnitudes and one restoring shift-subtract step.
  always_comb begin
    is_signed = ~bus.div_op[0];
    mag1      = cond_neg(bus.div_src1, is_signed & bus.div_src1[XLEN-1]);
    mag2      = cond_neg(bus.div_src2, is_signed & bus.div_src2[XLEN-1]);
    rem_sh    = {rem_q, quo_q[XLEN-1]};
    diff      = rem_sh - {2'b00, dvs_q};
    ge        = ~diff[XLEN+1];
    rem_nx    = ge ? diff[XLEN:0] : rem_sh[XLEN:0];
    quo_nx    = {quo_q[XLEN-2:0], ge};
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    sel_rem_d = sel_rem_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.kill && bus.start) begin
          sel_rem_d = bus.div_op[1];
          neg_q_d   = is_signed & (bus.div_src1[XLEN-1] ^ bus.div_src2[XLEN-1]);
          neg_r_d   = is_signed & bus.div_src1[XLEN-1];
          dvs_d     = mag2;
          quo_d     = mag1;
          rem_d     = '0;
          cnt_d     = '0;
          if (bus.div_src2 == '0) begin
            res_d   = bus.div_op[1] ? bus.div_src1 : '1;
            state_d = DONE;
          end else if (is_signed && bus.div_src1 == INT_MIN && bus.div_src2 == '1) begin
            res_d   = bus.div_op[1] ? '0 : INT_MIN;
            state_d = DONE;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (mag1 < mag2) begin
            res_d   = bus.div_op[1] ? bus.div_src1 : '0;
            state_d = DONE;
          end
`endif
          else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            res_d   = sel_rem_q ? cond_neg(rem_nx[XLEN-1:0], neg_r_q)
                                : cond_neg(quo_nx, neg_q_q);
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_rem_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_rem_q <= sel_rem_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
    end
  end

  // A kill arriving during DONE suppresses the pulse.
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.res_valid = (state_q == DONE) && !bus.kill;
    bus.div_res   = res_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit. Latency is measured as the number of
// rising edges after the acceptance edge at which res_valid is seen:
// 32 corresponds to cycle T+33, 0 to cycle T+1.
module tb_div_unit;

  localparam int LAT_NORM = 32;
  localparam int LAT_SPEC = 0;
`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_EARLY = 0;
`else
  localparam int LAT_EARLY = 32;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  div_if #(.XLEN(32), .OP_WIDTH(2)) bus ();

  div_unit #(.XLEN(32), .OP_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Issue one request, scramble the operands after acceptance, wait (bounded)
  // for res_valid, then step one more cycle so the unit is back in IDLE.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    res  = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.div_op   = op;
    bus.div_src1 = a;
    bus.div_src2 = b;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.div_op   = ~op;
    bus.div_src1 = ~a;
    bus.div_src2 = ~b ^ 32'h5;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (bus.res_valid) begin
        lat = k;
        res = bus.div_res;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    bus.div_op   = 2'b00;
    bus.div_src1 = '0;
    bus.div_src2 = '0;
    #12;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL reset res_valid: got %b want 0", bus.res_valid); end
    total++; if (bus.div_res !== 32'h0) begin bad++; $display("FAIL reset div_res: got %h want 00000000", bus.div_res); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [31:0] r; int lat, bc;
    do_op(2'b01, 32'd100, 32'd7, r, lat, bc);
    total++; if (r !== 32'd14) begin bad++; $display("FAIL divu_100_7 res: got %h want %h", r, 32'd14); end
    total++; if (lat !== LAT_NORM) begin bad++; $display("FAIL divu_100_7 latency: got %0d want %0d", lat, LAT_NORM); end
    total++; if (bc !== 33) begin bad++; $display("FAIL divu_100_7 busy cycles: got %0d want 33", bc); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL divu_100_7 busy after: got %b want 0", bus.busy); end
    do_op(2'b11, 32'd100, 32'd7, r, lat, bc);
    total++; if (r !== 32'd2) begin bad++; $display("FAIL remu_100_7 res: got %h want %h", r, 32'd2); end
    do_op(2'b01, 32'hFFFF_FFFF, 32'd16, r, lat, bc);
    total++; if (r !== 32'h0FFF_FFFF) begin bad++; $display("FAIL divu_max_16 res: got %h want 0fffffff", r); end
  endtask

  task automatic test_signed();
    logic [31:0] r; int lat, bc;
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, r, lat, bc);
    total++; if (r !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_m7_2 res: got %h want fffffffd", r); end
    total++; if (lat !== LAT_NORM) begin bad++; $display("FAIL div_m7_2 latency: got %0d want %0d", lat, LAT_NORM); end
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, r, lat, bc);
    total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rem_m7_2 res: got %h want ffffffff", r); end
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, r, lat, bc);
    total++; if (r !== 32'd1) begin bad++; $display("FAIL rem_7_m2 res: got %h want 00000001", r); end
    do_op(2'b00, 32'd7, 32'hFFFF_FFFE, r, lat, bc);
    total++; if (r !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_7_m2 res: got %h want fffffffd", r); end
  endtask

  task automatic test_special();
    logic [31:0] r; int lat, bc;
    do_op(2'b01, 32'd5, 32'd0, r, lat, bc);
    total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu_5_0 res: got %h want ffffffff", r); end
    total++; if (lat !== LAT_SPEC) begin bad++; $display("FAIL divu_5_0 latency: got %0d want %0d", lat, LAT_SPEC); end
    do_op(2'b00, 32'd5, 32'd0, r, lat, bc);
    total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_5_0 res: got %h want ffffffff", r); end
    do_op(2'b10, 32'd5, 32'd0, r, lat, bc);
    total++; if (r !== 32'd5) begin bad++; $display("FAIL rem_5_0 res: got %h want 00000005", r); end
    total++; if (lat !== LAT_SPEC) begin bad++; $display("FAIL rem_5_0 latency: got %0d want %0d", lat, LAT_SPEC); end
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc);
    total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf res: got %h want 80000000", r); end
    total++; if (lat !== LAT_SPEC) begin bad++; $display("FAIL div_ovf latency: got %0d want %0d", lat, LAT_SPEC); end
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL rem_ovf res: got %h want 00000000", r); end
  endtask

  task automatic test_kill();
    logic [31:0] r; int lat, bc; bit seen;
    seen = 1'b0;
    @(negedge clk);
    bus.div_op = 2'b01; bus.div_src1 = 32'd1000; bus.div_src2 = 32'd3; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    bus.kill = 1'b1;
    @(posedge clk);
    #1 bus.kill = 1'b0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL kill busy: got %b want 0", bus.busy); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL kill res_valid seen: got %b want 0", seen); end
    do_op(2'b01, 32'd9, 32'd3, r, lat, bc);
    total++; if (r !== 32'd3) begin bad++; $display("FAIL divu_9_3 after kill res: got %h want 00000003", r); end
    total++; if (lat !== LAT_NORM) begin bad++; $display("FAIL divu_9_3 after kill latency: got %0d want %0d", lat, LAT_NORM); end
  endtask

  task automatic test_start_ignored();
    logic [31:0] r; int lat;
    lat = -1;
    r   = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.div_op = 2'b01; bus.div_src1 = 32'd100; bus.div_src2 = 32'd7; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 4) begin
        bus.div_op = 2'b11; bus.div_src1 = 32'd200; bus.div_src2 = 32'd3; bus.start = 1'b1;
      end
      if (k == 5) bus.start = 1'b0;
      if (bus.res_valid) begin
        lat = k;
        r   = bus.div_res;
        break;
      end
    end
    total++; if (r !== 32'd14) begin bad++; $display("FAIL start_ignored res: got %h want 0000000e", r); end
    total++; if (lat !== LAT_NORM) begin bad++; $display("FAIL start_ignored latency: got %0d want %0d", lat, LAT_NORM); end
    repeat (4) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL start_ignored busy after: got %b want 0", bus.busy); end
    total++; if (bus.div_res !== 32'd14) begin bad++; $display("FAIL start_ignored div_res held: got %h want 0000000e", bus.div_res); end
  endtask

  task automatic test_async_rst();
    logic [31:0] r; int lat, bc;
    @(negedge clk);
    bus.div_op = 2'b01; bus.div_src1 = 32'd1000; bus.div_src2 = 32'd3; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL async_rst busy: got %b want 0", bus.busy); end
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL async_rst res_valid: got %b want 0", bus.res_valid); end
    total++; if (bus.div_res !== 32'h0) begin bad++; $display("FAIL async_rst div_res: got %h want 00000000", bus.div_res); end
    @(negedge clk);
    rst = 1'b0;
    do_op(2'b01, 32'd9, 32'd3, r, lat, bc);
    total++; if (r !== 32'd3) begin bad++; $display("FAIL divu_9_3 after rst res: got %h want 00000003", r); end
  endtask

  task automatic test_early_out();
    logic [31:0] r; int lat, bc;
    do_op(2'b01, 32'd3, 32'd10, r, lat, bc);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL divu_3_10 res: got %h want 00000000", r); end
    total++; if (lat !== LAT_EARLY) begin bad++; $display("FAIL divu_3_10 latency: got %0d want %0d", lat, LAT_EARLY); end
    do_op(2'b11, 32'd3, 32'd10, r, lat, bc);
    total++; if (r !== 32'd3) begin bad++; $display("FAIL remu_3_10 res: got %h want 00000003", r); end
    do_op(2'b10, 32'hFFFF_FFFD, 32'd10, r, lat, bc);
    total++; if (r !== 32'hFFFF_FFFD) begin bad++; $display("FAIL rem_m3_10 res: got %h want fffffffd", r); end
    total++; if (lat !== LAT_EARLY) begin bad++; $display("FAIL rem_m3_10 latency: got %0d want %0d", lat, LAT_EARLY); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_kill();
    test_start_ignored();
    test_async_rst();
    test_early_out();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
